t05_wb_sram_responder: RTL and testbench
========================================

Name: t05_wb_sram_responder

Overview:
- Wishbone classic subordinate: the responder end of the bus driven by the t05 Wishbone manager.
- Backs the bus with a small word-addressed register memory.
- Serves as the simulation and FPGA stand-in for the Caravel-side SRAM, so the histogram, FLV, hTree, CB and translation traffic generated by the SRAM interface can be closed-loop tested.
- Supports byte selects, configurable wait states and out-of-range detection.

Parameters:
- BASE_ADDR, 32'h3300_0000, byte address of word 0.
- DEPTH, 64, number of 32-bit words; must be a power of two, ≥ 2.
- WAIT_CYCLES, 0, extra idle cycles inserted between request capture and ack (0–15).

Ports:
- clk  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- wbs_cyc_i  input  1  bus cycle valid.
- wbs_stb_i  input  1  strobe, transfer request.
- wbs_we_i  input  1  1 = write, 0 = read.
- wbs_sel_i  input  4  byte lane enables; bit n covers data[8n+7:8n].
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  transfer acknowledge, single-cycle pulse.
- wbs_dat_o  output  32  read data, valid while wbs_ack_o = 1.
- oob_o  output  1  sticky flag: some access fell outside the memory window.

Behaviour:
- Clock and reset: one clock, clk. nRST is asynchronous and active-low.
- Reset, asynchronous on nRST low:
  - state = IDLE; wbs_ack_o = 0; wbs_dat_o = 0; oob_o = 0.
  - All DEPTH words cleared to 0; wait counter = 0.
- Request capture:
  - In IDLE, when wbs_cyc_i & wbs_stb_i are high at a rising edge, latch adr, we, sel and dat.
  - Move to WAIT if WAIT_CYCLES > 0, else to ACK.
- Address decode:
  - offset = adr − BASE_ADDR; index = offset[log2(DEPTH)+1:2].
  - In range iff adr ≥ BASE_ADDR and offset < 4·DEPTH.
  - adr[1:0] is ignored; accesses are word-aligned.
- State machine, states IDLE / WAIT / ACK:
  - IDLE → WAIT or ACK on request capture.
  - WAIT: counter loads WAIT_CYCLES−1 on entry and decrements each cycle. Go to ACK when the counter is 0.
  - ACK: wbs_ack_o = 1 for exactly this one cycle, then unconditionally back to IDLE.
- Timing with WAIT_CYCLES = 0: request sampled at edge k, ack high in cycle k+1. Total latency is 1 + WAIT_CYCLES cycles from capture to ack.
- Write commit:
  - Happens on the edge that enters ACK.
  - Per lane n with sel[n] = 1: mem[index][8n+7:8n] ← dat[8n+7:8n]. Lanes with sel[n] = 0 are unchanged.
  - sel = 4'b0000 writes nothing but is still acked.
- Read data:
  - wbs_dat_o is registered on the edge entering ACK.
  - Value is mem[index] with all 32 bits, regardless of sel.
  - wbs_dat_o returns to 0 when leaving ACK.
- Out of range:
  - Still acked with the same latency.
  - Writes are dropped; reads return 32'h0000_0000.
  - oob_o is set on the edge entering ACK and stays set until reset.
- Back-to-back transfers: a request already high in the cycle right after ACK (IDLE) is captured normally. There is no mandatory dead cycle beyond ACK→IDLE.
- Abort: if wbs_cyc_i or wbs_stb_i drops while in WAIT:
  - Return to IDLE next edge; no ack.
  - No write commit; oob_o unchanged.
- Request inputs are ignored in WAIT and ACK; they are not re-sampled.
- Reset mid-transfer:
  - Ack drops immediately and asynchronously.
  - Pending write is lost; memory is cleared.
- wbs_ack_o is never high for two consecutive cycles.

Decomposition:
- Shared package t05_pkg:
  - responder state enum (IDLE, WAIT, ACK);
  - WB_DATA_W = 32, WB_SEL_W = 4;
  - default SRAM base address constant, reused by the SRAM interface for its address map.
- One natural sub-module, t05_wb_byte_mem:
  - DEPTH×32 register array with async clear;
  - write port with per-lane enables;
  - combinational read at index.
- The FSM, decode and ack logic stay in the top of this block.

Test Plan:
- Reset, then write adr 0x3300_0008 dat 0xDEAD_BEEF sel 4'hF, WAIT_CYCLES = 0 → ack exactly one cycle, in the cycle after capture. Read of the same address → wbs_dat_o = 0xDEAD_BEEF with the ack.
- Pre-load word 3 with 0x1122_3344, then write 0xAABB_CCDD with sel 4'b0101 → readback 0x11BB_33DD.
- WAIT_CYCLES = 3: read request → ack 4 cycles after capture. Drop stb after 2 wait cycles → no ack, memory unchanged, next request serviced normally.
- Write 0x5 to 0x3300_0100 (DEPTH = 64, out of range) → acked, oob_o = 1 and remains 1. Read 0x32FF_FFFC → returns 0. Words 0–63 are unchanged.
- Back-to-back: write word 1 = 0x1, with the next request already asserted in the cycle after ack (read word 1) → second ack returns 0x1; ack never high 2 cycles in a row.
- Assert nRST low while in WAIT during a write of 0x7 to word 0 → ack = 0 immediately. After release, a read of word 0 returns 0 and oob_o = 0.

Source files
------------

// File: rtl/t05_pkg.sv
// ---------------------------------------------------------------------------
// t05_pkg
// Shared definitions for the t05 Wishbone fabric.
//   - WB_DATA_W / WB_SEL_W : Wishbone data and byte-select widths
//   - SRAM_BASE_ADDR       : default byte address of the SRAM window; the SRAM
//                            interface uses the same constant for its map
//   - resp_state_e         : responder FSM states
// ---------------------------------------------------------------------------
package t05_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'h3300_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } resp_state_e;

endpackage

// File: rtl/t05_wb_sram_responder_if.sv
// ---------------------------------------------------------------------------
// t05_wb_sram_responder_if
// Wishbone classic bus bundle between the t05 manager and the SRAM responder.
//   master modport : drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave  modport : receives cyc/stb/we/sel/adr/dat_i, drives ack/dat_o
// ---------------------------------------------------------------------------
interface t05_wb_sram_responder_if;
  import t05_pkg::*;

  logic                 wbs_cyc_i;
  logic                 wbs_stb_i;
  logic                 wbs_we_i;
  logic [WB_SEL_W-1:0]  wbs_sel_i;
  logic [31:0]          wbs_adr_i;
  logic [WB_DATA_W-1:0] wbs_dat_i;
  logic                 wbs_ack_o;
  logic [WB_DATA_W-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/t05_wb_byte_mem.sv
// ---------------------------------------------------------------------------
// t05_wb_byte_mem
// DEPTH x 32-bit register memory built as four independent byte lanes.
//   clk, nRST : clock / asynchronous active-low clear of every word
//   we_i      : write strobe; lane n is written when sel_i[n] is also set
//   sel_i     : byte lane enables
//   waddr_i   : word index for the write
//   wdata_i   : write data
//   raddr_i   : word index for the combinational read
//   rdata_o   : full 32-bit word at raddr_i
// ---------------------------------------------------------------------------
module t05_wb_byte_mem
  import t05_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 we_i,
  input  logic [WB_SEL_W-1:0]  sel_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [WB_DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [WB_DATA_W-1:0] rdata_o
);

  // One array per byte lane so each lane has a single, independent driver.
  for (genvar gi = 0; gi < WB_SEL_W; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];

    always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
        for (int i = 0; i < DEPTH; i++) begin
          lane_q[i] <= 8'h00;
        end
      end else if (we_i && sel_i[gi]) begin
        lane_q[waddr_i] <= wdata_i[8*gi +: 8];
      end
    end

    assign rdata_o[8*gi +: 8] = lane_q[raddr_i];
  end

endmodule

// File: rtl/t05_wb_sram_responder.sv
// ---------------------------------------------------------------------------
// t05_wb_sram_responder
// Wishbone classic subordinate backed by a small word-addressed memory;
// stands in for the Caravel-side SRAM in simulation and on FPGA.
//   clk   : system clock, rising edge
//   nRST  : asynchronous active-low reset
//   wbs   : Wishbone slave bundle (cyc/stb/we/sel/adr/dat_i in, ack/dat_o out)
//   oob_o : sticky flag, set once any access falls outside the window
// Latency from request capture to ack is 1 + WAIT_CYCLES cycles.
// ---------------------------------------------------------------------------
module t05_wb_sram_responder
  import t05_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      nRST,
  t05_wb_sram_responder_if.slave    wbs,
  output logic                      oob_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  resp_state_e          state_q, state_d;
  logic [31:0]          adr_q,   adr_d;
  logic                 we_q,    we_d;
  logic [WB_SEL_W-1:0]  sel_q,   sel_d;
  logic [WB_DATA_W-1:0] dat_q,   dat_d;
  logic [3:0]           cnt_q,   cnt_d;
  logic                 ack_q,   ack_d;
  logic [WB_DATA_W-1:0] rdat_q,  rdat_d;
  logic                 oob_q,   oob_d;

  logic                 req_valid;
  logic [31:0]          cur_adr;
  logic                 cur_we;
  logic [WB_SEL_W-1:0]  cur_sel;
  logic [WB_DATA_W-1:0] cur_dat;
  logic [31:0]          offset;
  logic                 in_range;
  logic [AW-1:0]        index;
  logic                 enter_ack;
  logic                 mem_we;
  logic [WB_DATA_W-1:0] mem_rdata;

  assign req_valid = wbs.wbs_cyc_i & wbs.wbs_stb_i;

  // With no wait states the ACK-entry edge is the capture edge itself, so the
  // live bus has to feed decode/commit then; afterwards the latched copy does.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_adr = wbs.wbs_adr_i;
      cur_we  = wbs.wbs_we_i;
      cur_sel = wbs.wbs_sel_i;
      cur_dat = wbs.wbs_dat_i;
    end else begin
      cur_adr = adr_q;
      cur_we  = we_q;
      cur_sel = sel_q;
      cur_dat = dat_q;
    end
  end

  // Address decode. The subtraction may wrap for addresses below the base,
  // hence the separate lower-bound test. adr[1:0] is dropped by the slice.
  assign offset   = cur_adr - BASE_ADDR;
  assign in_range = (cur_adr >= BASE_ADDR) && (offset < WIN_BYTES);
  assign index    = offset[AW+1:2];

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    rdat_d    = '0;
    oob_d     = oob_q;
    enter_ack = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          adr_d = wbs.wbs_adr_i;
          we_d  = wbs.wbs_we_i;
          sel_d = wbs.wbs_sel_i;
          dat_d = wbs.wbs_dat_i;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            enter_ack = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Manager withdrew the request: abandon silently, no commit.
        if (!req_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_ack) begin
      state_d = ST_ACK;
      ack_d   = 1'b1;
      rdat_d  = (in_range && !cur_we) ? mem_rdata : '0;
      oob_d   = oob_q | ~in_range;
    end
  end

  assign mem_we = enter_ack & cur_we & in_range;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      oob_q   <= oob_d;
    end
  end

  t05_wb_byte_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .nRST    (nRST),
    .we_i    (mem_we),
    .sel_i   (cur_sel),
    .waddr_i (index),
    .wdata_i (cur_dat),
    .raddr_i (index),
    .rdata_o (mem_rdata)
  );

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = rdat_q;
  assign oob_o         = oob_q;

endmodule

// File: tb/tb_t05_wb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_t05_wb_sram_responder
// Directed bench for the SRAM responder: dut0 has no wait states, dut3 has
// three. Both share clk and nRST. One line is printed per bus transfer.
// ---------------------------------------------------------------------------
module tb_t05_wb_sram_responder;

  logic clk;
  logic nRST;
  logic oob0;
  logic oob3;
  int   checks = 0;
  int   errors = 0;

  t05_wb_sram_responder_if bus0 ();
  t05_wb_sram_responder_if bus3 ();

  t05_wb_sram_responder #(
    .BASE_ADDR   (32'h3300_0000),
    .DEPTH       (64),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk   (clk),
    .nRST  (nRST),
    .wbs   (bus0),
    .oob_o (oob0)
  );

  t05_wb_sram_responder #(
    .BASE_ADDR   (32'h3300_0000),
    .DEPTH       (64),
    .WAIT_CYCLES (3)
  ) dut3 (
    .clk   (clk),
    .nRST  (nRST),
    .wbs   (bus3),
    .oob_o (oob3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int which, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (which == 0) begin
      bus0.wbs_cyc_i = cyc; bus0.wbs_stb_i = stb; bus0.wbs_we_i = we;
      bus0.wbs_adr_i = adr; bus0.wbs_sel_i = sel; bus0.wbs_dat_i = dat;
    end else begin
      bus3.wbs_cyc_i = cyc; bus3.wbs_stb_i = stb; bus3.wbs_we_i = we;
      bus3.wbs_adr_i = adr; bus3.wbs_sel_i = sel; bus3.wbs_dat_i = dat;
    end
  endtask

  function automatic logic get_ack(input int which);
    return (which == 0) ? bus0.wbs_ack_o : bus3.wbs_ack_o;
  endfunction

  function automatic logic [31:0] get_dat(input int which);
    return (which == 0) ? bus0.wbs_dat_o : bus3.wbs_dat_o;
  endfunction

  // Issue one transfer, wait (bounded) for ack, then look one cycle further:
  // ack must have dropped and read data returned to zero. With hold set the
  // request stays asserted so the caller can chain the next one immediately.
  task automatic do_xfer(input int which, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat, input bit hold,
                         output logic [31:0] rdat, output int lat);
    lat  = -1;
    rdat = 32'hxxxx_xxxx;
    set_req(which, 1'b1, 1'b1, we, adr, sel, dat);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (get_ack(which)) begin
        lat  = n;
        rdat = get_dat(which);
        break;
      end
    end
    if (!hold) set_req(which, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    $display("xfer bus=%0d we=%0b adr=%h sel=%h wdat=%h rdat=%h lat=%0d",
             which == 0 ? 0 : 3, we, adr, sel, dat, rdat, lat);
    @(posedge clk);
    #1;
    check("ack_single_cycle", {31'd0, get_ack(which)}, 32'd0);
    check("dat_cleared_after_ack", get_dat(which), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;

    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(3, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nRST = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack0", {31'd0, bus0.wbs_ack_o}, 32'd0);
    check("rst_dat0", bus0.wbs_dat_o, 32'd0);
    check("rst_oob0", {31'd0, oob0}, 32'd0);
    check("rst_ack3", {31'd0, bus3.wbs_ack_o}, 32'd0);
    check("rst_oob3", {31'd0, oob3}, 32'd0);
    nRST = 1'b1;
    @(negedge clk);

    // Basic write/read, zero wait states.
    do_xfer(0, 1'b1, 32'h3300_0008, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, lat);
    check("wr_lat_w0", lat, 32'd1);
    do_xfer(0, 1'b0, 32'h3300_0008, 4'hF, 32'h0, 1'b0, rd, lat);
    check("rd_lat_w0", lat, 32'd1);
    check("rd_word2", rd, 32'hDEAD_BEEF);
    // Low address bits ignored; sel ignored on reads.
    do_xfer(0, 1'b0, 32'h3300_000B, 4'h1, 32'h0, 1'b0, rd, lat);
    check("rd_unaligned", rd, 32'hDEAD_BEEF);
    // sel = 0 write is acked but changes nothing.
    do_xfer(0, 1'b1, 32'h3300_0008, 4'h0, 32'h0000_0000, 1'b0, rd, lat);
    check("sel0_lat", lat, 32'd1);
    do_xfer(0, 1'b0, 32'h3300_0008, 4'hF, 32'h0, 1'b0, rd, lat);
    check("sel0_no_write", rd, 32'hDEAD_BEEF);

    // Byte-lane merge.
    do_xfer(0, 1'b1, 32'h3300_000C, 4'hF, 32'h1122_3344, 1'b0, rd, lat);
    do_xfer(0, 1'b1, 32'h3300_000C, 4'h5, 32'hAABB_CCDD, 1'b0, rd, lat);
    do_xfer(0, 1'b0, 32'h3300_000C, 4'hF, 32'h0, 1'b0, rd, lat);
    check("lane_merge", rd, 32'h11BB_33DD);

    // Last word of the window is in range.
    do_xfer(0, 1'b1, 32'h3300_00FC, 4'hF, 32'h0000_0063, 1'b0, rd, lat);
    do_xfer(0, 1'b0, 32'h3300_00FC, 4'hF, 32'h0, 1'b0, rd, lat);
    check("top_word", rd, 32'h0000_0063);
    check("oob_clear_in_range", {31'd0, oob0}, 32'd0);

    // Out of range above and below the window.
    do_xfer(0, 1'b1, 32'h3300_0100, 4'hF, 32'h0000_0005, 1'b0, rd, lat);
    check("oob_wr_lat", lat, 32'd1);
    check("oob_set", {31'd0, oob0}, 32'd1);
    do_xfer(0, 1'b0, 32'h32FF_FFFC, 4'hF, 32'h0, 1'b0, rd, lat);
    check("oob_rd_lat", lat, 32'd1);
    check("oob_rd_zero", rd, 32'h0);
    check("oob_sticky", {31'd0, oob0}, 32'd1);
    do_xfer(0, 1'b0, 32'h3300_0000, 4'hF, 32'h0, 1'b0, rd, lat);
    check("oob_no_alias_w0", rd, 32'h0);
    do_xfer(0, 1'b0, 32'h3300_00FC, 4'hF, 32'h0, 1'b0, rd, lat);
    check("oob_top_intact", rd, 32'h0000_0063);

    // Back-to-back: request stays asserted through ACK and the IDLE cycle.
    do_xfer(0, 1'b1, 32'h3300_0004, 4'hF, 32'h0000_0001, 1'b1, rd, lat);
    check("b2b_wr_lat", lat, 32'd1);
    do_xfer(0, 1'b0, 32'h3300_0004, 4'hF, 32'h0, 1'b0, rd, lat);
    check("b2b_rd_lat", lat, 32'd1);
    check("b2b_rd_data", rd, 32'h0000_0001);

    // Three wait states.
    do_xfer(3, 1'b1, 32'h3300_0014, 4'hF, 32'h0000_0055, 1'b0, rd, lat);
    check("w3_wr_lat", lat, 32'd4);
    do_xfer(3, 1'b0, 32'h3300_0014, 4'hF, 32'h0, 1'b0, rd, lat);
    check("w3_rd_lat", lat, 32'd4);
    check("w3_rd_data", rd, 32'h0000_0055);

    // Abort: strobe dropped after two wait cycles.
    set_req(3, 1'b1, 1'b1, 1'b1, 32'h3300_0014, 4'hF, 32'h0000_0099);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check("abort_no_ack_wait", {31'd0, bus3.wbs_ack_o}, 32'd0);
    end
    set_req(3, 1'b1, 1'b0, 1'b1, 32'h3300_0014, 4'hF, 32'h0000_0099);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      check("abort_no_ack_after", {31'd0, bus3.wbs_ack_o}, 32'd0);
    end
    set_req(3, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    $display("xfer bus=3 we=1 adr=33000014 sel=f wdat=00000099 aborted");
    do_xfer(3, 1'b0, 32'h3300_0014, 4'hF, 32'h0, 1'b0, rd, lat);
    check("abort_next_lat", lat, 32'd4);
    check("abort_mem_kept", rd, 32'h0000_0055);
    check("abort_oob3", {31'd0, oob3}, 32'd0);

    // Reset mid-transfer: dut0 in ACK, dut3 in WAIT.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h3300_0000, 4'hF, 32'h0000_0007);
    set_req(3, 1'b1, 1'b1, 1'b1, 32'h3300_0000, 4'hF, 32'h0000_0007);
    @(posedge clk);
    #1;
    check("rst_pre_ack0", {31'd0, bus0.wbs_ack_o}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("rst_async_ack0", {31'd0, bus0.wbs_ack_o}, 32'd0);
    check("rst_async_ack3", {31'd0, bus3.wbs_ack_o}, 32'd0);
    check("rst_async_oob0", {31'd0, oob0}, 32'd0);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(3, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    $display("xfer bus=0,3 we=1 adr=33000000 wdat=00000007 reset mid-transfer");
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    do_xfer(3, 1'b0, 32'h3300_0000, 4'hF, 32'h0, 1'b0, rd, lat);
    check("rst_w3_word0", rd, 32'h0);
    check("rst_w3_lat", lat, 32'd4);
    do_xfer(0, 1'b0, 32'h3300_0000, 4'hF, 32'h0, 1'b0, rd, lat);
    check("rst_w0_word0", rd, 32'h0);
    do_xfer(0, 1'b0, 32'h3300_0008, 4'hF, 32'h0, 1'b0, rd, lat);
    check("rst_w0_word2_cleared", rd, 32'h0);
    check("rst_oob0_after", {31'd0, oob0}, 32'd0);
    check("rst_oob3_after", {31'd0, oob3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
